// File: rtl/ft601_pkg.sv
// Shared word type and sizing helpers for the FT601 245-mode FIFO emulator.
package ft601_pkg;

    localparam int FT601_DATA_W = 32;

    typedef logic [FT601_DATA_W-1:0] ft601_word_t;

    // Occupancy counters need one extra bit so that a full FIFO is distinguishable from empty.
    function automatic int ft601_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ft601_emu_fifo.sv
// First-word-fall-through FIFO with synchronous flush; head_o always shows the oldest entry.
module ft601_emu_fifo
    import ft601_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  ft601_word_t                   data_i,
    output ft601_word_t                   head_o,
    output logic [ft601_cnt_w(DEPTH)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = ft601_cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ft601_word_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && (count_q != FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ft601_fifo_emulator.sv
// FT601 245 synchronous FIFO emulator: controller writes fill TX, controller reads drain RX.
// Define FT601_EMU_LOOPBACK_EN to route the TX FIFO straight into the RX FIFO instead of the host streams.
module ft601_fifo_emulator
    import ft601_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        usb_wren_l,
    input  logic        usb_rden_l,
    input  logic        usb_outen_l,
    input  logic        usb_rst_l,
    output logic        usb_tx_full,
    output logic        usb_rx_empty,
    input  ft601_word_t bus_from_ctrl,
    output ft601_word_t bus_to_ctrl,
    output logic        bus_to_ctrl_oe,
    input  ft601_word_t host_tx_data,
    input  logic        host_tx_valid,
    output logic        host_tx_ready,
    output ft601_word_t host_rx_data,
    output logic        host_rx_valid,
    input  logic        host_rx_ready,
    output logic        err_overflow,
    output logic        err_underflow,
    output logic        err_bus_conflict
);

    localparam int CW = ft601_cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    ft601_word_t   tx_head;
    ft601_word_t   rx_head;
    ft601_word_t   rx_push_data;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic          flush;
    logic          ctrl_wr;
    logic          ctrl_rd;
    logic          run_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          conf_q, conf_d;

    assign flush          = ~usb_rst_l;
    assign usb_tx_full    = (tx_count == FULL_CNT);
    assign usb_rx_empty   = (rx_count == '0);
    assign bus_to_ctrl_oe = ~usb_outen_l;
    assign bus_to_ctrl    = usb_rx_empty ? '0 : rx_head;

    // A write during a bus conflict still lands in TX, but the read side is suppressed.
    assign ctrl_wr = ~usb_wren_l & usb_rst_l;
    assign ctrl_rd = ~usb_rden_l & ~usb_outen_l & usb_rst_l;
    assign tx_push = ctrl_wr & ~usb_tx_full;
    assign rx_pop  = ctrl_rd & usb_wren_l & ~usb_rx_empty;

`ifdef FT601_EMU_LOOPBACK_EN
    logic lb_xfer;
    logic unused_lb;

    assign lb_xfer       = usb_rst_l & (tx_count != '0) & (rx_count != FULL_CNT);
    assign tx_pop        = lb_xfer;
    assign rx_push       = lb_xfer;
    assign rx_push_data  = tx_head;
    assign host_tx_ready = 1'b0;
    assign host_rx_valid = 1'b0;
    assign host_rx_data  = '0;
    assign unused_lb     = ^{host_tx_data, host_tx_valid, host_rx_ready, run_q};
`else
    assign host_tx_ready = run_q & usb_rst_l & (rx_count != FULL_CNT);
    assign host_rx_valid = usb_rst_l & (tx_count != '0);
    assign host_rx_data  = (tx_count != '0) ? tx_head : '0;
    assign tx_pop        = host_rx_valid & host_rx_ready;
    assign rx_push       = host_tx_valid & host_tx_ready;
    assign rx_push_data  = host_tx_data;
`endif

    always_comb begin
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        conf_d = conf_q;
        if (!usb_rst_l) begin
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            conf_d = 1'b0;
        end else begin
            if (ctrl_wr && usb_tx_full) begin
                ovf_d = 1'b1;
            end
            if (ctrl_rd && usb_rx_empty) begin
                unf_d = 1'b1;
            end
            if (ctrl_wr && !usb_outen_l) begin
                conf_d = 1'b1;
            end
        end
    end

    // run_q keeps host_tx_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            conf_q <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            conf_q <= conf_d;
        end
    end

    assign err_overflow     = ovf_q;
    assign err_underflow    = unf_q;
    assign err_bus_conflict = conf_q;

    ft601_emu_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .data_i  (bus_from_ctrl),
        .head_o  (tx_head),
        .count_o (tx_count)
    );

    ft601_emu_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .data_i  (rx_push_data),
        .head_o  (rx_head),
        .count_o (rx_count)
    );

endmodule

// File: tb/tb_ft601_fifo_emulator.sv
// Directed plus random bench for ft601_fifo_emulator, checked against a queue-based model of the FT601 rules.
module tb_ft601_fifo_emulator;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        usbWrenL, usbRdenL, usbOutenL, usbRstL;
    logic        usbTxFull, usbRxEmpty;
    logic [31:0] busFromCtrl, busToCtrl;
    logic        busToCtrlOe;
    logic [31:0] hostTxData, hostRxData;
    logic        hostTxValid, hostTxReady, hostRxValid, hostRxReady;
    logic        errOverflow, errUnderflow, errBusConflict;

    logic [31:0] txQ[$];
    logic [31:0] rxQ[$];
    bit          mOvf, mUnf, mConf, mRun;
    int          errors = 0;
    int          checks = 0;
    int          stepNo = 0;

    ft601_fifo_emulator #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .usb_wren_l       (usbWrenL),
        .usb_rden_l       (usbRdenL),
        .usb_outen_l      (usbOutenL),
        .usb_rst_l        (usbRstL),
        .usb_tx_full      (usbTxFull),
        .usb_rx_empty     (usbRxEmpty),
        .bus_from_ctrl    (busFromCtrl),
        .bus_to_ctrl      (busToCtrl),
        .bus_to_ctrl_oe   (busToCtrlOe),
        .host_tx_data     (hostTxData),
        .host_tx_valid    (hostTxValid),
        .host_tx_ready    (hostTxReady),
        .host_rx_data     (hostRxData),
        .host_rx_valid    (hostRxValid),
        .host_rx_ready    (hostRxReady),
        .err_overflow     (errOverflow),
        .err_underflow    (errUnderflow),
        .err_bus_conflict (errBusConflict)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s@%0d observed=0x%08h expected=0x%08h", tag, stepNo, observed, expected);
        end
    endtask

    task automatic modelReset();
        txQ.delete();
        rxQ.delete();
        mOvf = 0; mUnf = 0; mConf = 0; mRun = 0;
    endtask

    // Compare every output against what the model says should be visible before the next edge.
    task automatic checkAll();
        logic [31:0] expBus, expTxHead;
        bit loopback;
`ifdef FT601_EMU_LOOPBACK_EN
        loopback = 1;
`else
        loopback = 0;
`endif
        expBus    = (rxQ.size() > 0) ? rxQ[0] : 32'h0;
        expTxHead = (txQ.size() > 0) ? txQ[0] : 32'h0;
        checkOutput("usb_tx_full", 32'(usbTxFull), 32'(txQ.size() == DEPTH));
        checkOutput("usb_rx_empty", 32'(usbRxEmpty), 32'(rxQ.size() == 0));
        checkOutput("bus_to_ctrl_oe", 32'(busToCtrlOe), 32'(!usbOutenL));
        checkOutput("bus_to_ctrl", busToCtrl, expBus);
        checkOutput("err_overflow", 32'(errOverflow), 32'(mOvf));
        checkOutput("err_underflow", 32'(errUnderflow), 32'(mUnf));
        checkOutput("err_bus_conflict", 32'(errBusConflict), 32'(mConf));
        if (usbRstL || !rst) begin
            checkOutput("host_tx_ready", 32'(hostTxReady),
                        32'(!loopback && mRun && rxQ.size() < DEPTH));
            checkOutput("host_rx_valid", 32'(hostRxValid), 32'(!loopback && txQ.size() > 0));
            if (loopback) begin
                checkOutput("host_rx_data", hostRxData, 32'h0);
            end else if (txQ.size() > 0) begin
                checkOutput("host_rx_data", hostRxData, expTxHead);
            end
        end
    endtask

    // Apply one rising edge's worth of FT601 rules to the model, using the inputs currently driven.
    task automatic modelEdge();
        int  txN, rxN;
        bit  wr, rd, ctrlPop, hostPush, hostPop, xfer;
        logic [31:0] w;
        if (!rst) return;
        if (!usbRstL) begin
            txQ.delete();
            rxQ.delete();
            mOvf = 0; mUnf = 0; mConf = 0; mRun = 1;
            return;
        end
        txN = txQ.size();
        rxN = rxQ.size();
        wr  = !usbWrenL;
        rd  = !usbRdenL && !usbOutenL;
        if (wr && txN == DEPTH) mOvf = 1;
        if (wr && !usbOutenL)   mConf = 1;
        if (rd && rxN == 0)     mUnf = 1;
        ctrlPop = rd && usbWrenL && rxN > 0;
`ifdef FT601_EMU_LOOPBACK_EN
        xfer     = txN > 0 && rxN < DEPTH;
        hostPush = 0;
        hostPop  = 0;
`else
        xfer     = 0;
        hostPush = hostTxValid && mRun && rxN < DEPTH;
        hostPop  = hostRxReady && txN > 0;
`endif
        if (ctrlPop) void'(rxQ.pop_front());
        if (hostPop) void'(txQ.pop_front());
        if (xfer) begin
            w = txQ.pop_front();
            rxQ.push_back(w);
        end
        if (wr && txN < DEPTH) txQ.push_back(busFromCtrl);
        if (hostPush) rxQ.push_back(hostTxData);
        mRun = 1;
    endtask

    task automatic applyStimulus(input logic wrL, input logic rdL, input logic oeL, input logic urL,
                                 input logic [31:0] bus, input logic txV, input logic [31:0] txD,
                                 input logic rxR);
        usbWrenL    = wrL;
        usbRdenL    = rdL;
        usbOutenL   = oeL;
        usbRstL     = urL;
        busFromCtrl = bus;
        hostTxValid = txV;
        hostTxData  = txD;
        hostRxReady = rxR;
        stepNo++;
        #1 checkAll();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 1, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b0;
        modelReset();
        usbWrenL = 1; usbRdenL = 1; usbOutenL = 1; usbRstL = 1;
        busFromCtrl = 0; hostTxValid = 0; hostTxData = 0; hostRxReady = 0;
        #2 checkAll();
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        idle(2);

        $display("[TB] four controller writes streamed out to the host");
        applyStimulus(0, 1, 1, 1, 32'h11111111, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 32'h22222222, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 32'h33333333, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 32'h44444444, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);

        $display("[TB] TX overflow with the host stalled");
        for (int i = 0; i <= DEPTH; i++) applyStimulus(0, 1, 1, 1, 32'hC000_0000 + i, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        idle(1);

        $display("[TB] single host word read back then underflow");
        applyStimulus(1, 1, 1, 1, 0, 1, 32'hA5A5A5A5, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
        idle(1);

        $display("[TB] RX near full with simultaneous host push and controller pop");
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1, 1, 1, 1, 0, 1, $urandom, 0);
        applyStimulus(1, 0, 0, 1, 0, 1, $urandom, 0);
        applyStimulus(1, 1, 1, 1, 0, 1, $urandom, 0);
        applyStimulus(1, 0, 0, 1, 0, 1, $urandom, 0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);

        $display("[TB] usb_rst_l flush with both FIFOs half full");
        for (int i = 0; i < DEPTH / 2; i++) applyStimulus(0, 1, 1, 1, $urandom, 1, $urandom, 0);
        applyStimulus(0, 1, 0, 1, 32'h5, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 1, 32'h77, 1);
        idle(2);

        $display("[TB] asynchronous reset in the middle of a write burst");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, $urandom, 1, $urandom, 0);
        #2 rst = 1'b0;
        modelReset();
        #1 checkAll();
        applyStimulus(0, 1, 1, 1, 32'h9, 1, 32'h9, 1);
        applyStimulus(0, 1, 1, 1, 32'hA, 1, 32'hA, 1);
        rst = 1'b1;
        idle(2);

`ifdef FT601_EMU_LOOPBACK_EN
        $display("[TB] loopback of a single word");
        applyStimulus(0, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0);
        idle(2);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                          1'(($urandom % 32) != 0), $urandom, 1'($urandom % 2), $urandom,
                          1'($urandom % 2));
        end
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
